cordic_ctrl: RTL and testbench
==============================

# cordic_ctrl

Sequencing controller for the 16-bit iterative CORDIC datapath. Accepts one angle request at a time over a valid/ready handshake and reduces the angle to a quadrant plus residual. Loads the datapath, runs it until its `done` flag, then captures sine/cosine into a held response register. Sits between the system request bus and the datapath; the datapath is never exposed directly to requesters.

## Interface
- `ITER`, 12: datapath iteration count; informational, used only for the timeout default.
- `TIMEOUT`, 16: maximum RUN cycles before an error response is issued.
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (IDLE only)
- `req_angle`  in  16  angle, binary angle units: 0x0000=0°, 0x4000=90°, wraps mod 360°
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts response
- `rsp_sin`, `rsp_cos`  out  16  signed Q2.14 results
- `rsp_err`  out  1  response produced by timeout
- `dp_rst`  out  1  datapath load/reset, active high
- `dp_cnt_en`  out  1  datapath iteration counter enable
- `dp_angle`  out  16  signed Q2.14 radian residual to datapath
- `dp_sector`  out  2  quadrant to datapath
- `dp_done`  in  1  datapath finished
- `dp_sin`, `dp_cos`  in  16  datapath live y / x registers

## Operation
- States: IDLE, CONV, LOAD, RUN, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, register `sector`=`req_angle[15:14]` and `r`=`req_angle[13:0]`, then go to CONV.
- CONV: `rad` = (`r`·25736 + 8192) >> 14, unsigned, max 25734.
  - Sectors 00/01: `dp_angle`=`rad`.
  - Sectors 10/11: `dp_angle`=`rad` − 0x6488.
  - Register the result and go to LOAD.
- LOAD: `dp_rst`=1 with `dp_sector`/`dp_angle` stable. Go to RUN next cycle.
- RUN: `dp_rst`=0, `dp_cnt_en`=1, and a RUN cycle counter increments.
  - On `dp_done`=1, capture `dp_sin`/`dp_cos` into `rsp_sin`/`rsp_cos` with `rsp_err`=0, then go to RESP.
  - If the counter reaches `TIMEOUT` without `dp_done`, set `rsp_sin`=`rsp_cos`=0 and `rsp_err`=1, then go to RESP.
  - `dp_done` on the timeout cycle itself takes priority, giving a normal capture.
- RESP: `rsp_valid`=1, and `dp_rst`=1 parks the datapath. Response fields stay stable until `rsp_ready`, then go to IDLE. No new request is accepted in the same cycle.
- `dp_rst` = 1 in every state except RUN, and also whenever `rst_n`=0 (combinational OR, so the datapath is parked during reset).
- `dp_cnt_en` = 1 only in RUN.
- `dp_sector`/`dp_angle` hold their last value outside LOAD/RUN.
- Width rule: product is 30 bits; the Q2.14 subtract is done in 17 bits signed and fits in 16.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_sin`=`rsp_cos`=0, `rsp_err`=0, `dp_cnt_en`=0, `dp_rst`=1, `dp_angle`=0, `dp_sector`=0.
- Acceptance edge = cycle 0. CONV = cycle 1, LOAD = cycle 2, RUN begins cycle 3.
- With a nominal datapath, `dp_done` rises on the `ITER`-th RUN cycle. `rsp_valid` rises the cycle after `dp_done` is sampled, i.e. cycle 3+`ITER` = 15.
- Timeout path: `rsp_valid` rises `TIMEOUT` cycles after RUN entry.
- `rsp_valid` held under backpressure indefinitely; `req_ready` stays 0 throughout.
- Minimum spacing between accepted requests: `ITER`+4 cycles when `rsp_ready` is tied high.
- Reset asserted mid-operation: immediate return to IDLE with reset values; any in-flight result is discarded.
- `dp_done` seen outside RUN is ignored.

## Structure
- Package `cordic_pkg`: state enum, `HALF_PI_Q14`=16'h6488, `RAD_PER_QUAD`=25736, `Q14_ONE`=16'h4000.
- Sub-module `bam_to_rad`: combinational residual→radian conversion with rounding and sector offset. Instantiated once, output registered in CONV.
- Everything else (FSM, RUN counter, response register) lives in `cordic_ctrl`.

## Test plan
- `req_angle`=0x0000 with the real datapath → `rsp_cos`≈0x4000, `rsp_sin`≈0x0000 (±8 LSB), `rsp_err`=0; `rsp_valid` at cycle 15.
- `req_angle`=0x4000 → `dp_sector`=01, `dp_angle`=0x0000; `rsp_sin`≈0x4000, `rsp_cos`≈0x0000.
- `req_angle`=0xA000 → `dp_sector`=10, `dp_angle`=0xCDBC (−0x3244); `rsp_sin`≈`rsp_cos`≈0xD2BF. `req_angle`=0xE000 → sin≈0xD2BF, cos≈0x2D41.
- Hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → outputs stable, `req_ready`=0, `dp_rst`=1. Pulse `rsp_ready` → IDLE next cycle.
- Stub datapath with `dp_done` tied 0 → after 16 RUN cycles `rsp_valid`=1, `rsp_err`=1, sin=cos=0.
- Assert `rst_n`=0 at RUN cycle 5 → `rsp_valid`=0, `dp_rst`=1, `dp_cnt_en`=0 immediately. After release, a new request completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and fixed-point constants for the CORDIC sequencing controller.
// Angles on the datapath side are signed Q2.14 radians.
package cordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD,
        ST_RUN,
        ST_RESP
    } state_t;

    localparam logic [15:0] HALF_PI_Q14  = 16'h6488;
    localparam int unsigned RAD_PER_QUAD = 25736;
    localparam logic [15:0] Q14_ONE      = 16'h4000;

endpackage

// File: rtl/cordic_ctrl_if.sv
// Request/response bus between system requesters and the CORDIC controller.
// master = requester/consumer side, slave = controller side.
interface cordic_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_angle;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sin;
    logic [15:0] rsp_cos;
    logic        rsp_err;

    modport master (
        output req_valid, req_angle, rsp_ready,
        input  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err
    );

    modport slave (
        input  req_valid, req_angle, rsp_ready,
        output req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err
    );

endinterface

// File: rtl/bam_to_rad.sv
// Converts a 14-bit in-quadrant binary angle to a rounded Q2.14 radian residual.
// Lower-half-plane sectors are re-based by -pi/2 so the datapath sees a small angle.
module bam_to_rad
    import cordic_pkg::*;
(
    input  logic [1:0]  i_sector,
    input  logic [13:0] i_resid,
    output logic [15:0] o_angle
);

    logic [29:0]        w_prod;
    logic [15:0]        w_rad;
    logic signed [16:0] w_diff;

    always_comb begin
        // Round-to-nearest before dropping the 14 fractional bits of the scale.
        w_prod = 30'(i_resid) * 30'(RAD_PER_QUAD) + 30'(Q14_ONE >> 1);
        w_rad  = 16'(w_prod >> 14);
        w_diff = $signed({1'b0, w_rad}) - $signed({1'b0, HALF_PI_Q14});
        case (i_sector)
            2'b00, 2'b01: o_angle = w_rad;
            default:      o_angle = 16'(w_diff);
        endcase
    end

endmodule

// File: rtl/cordic_ctrl.sv
// Sequencing controller for the iterative 16-bit CORDIC datapath: accepts one
// angle, loads and runs the datapath, and holds the sin/cos result until taken.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int ITER    = 12,
    parameter int TIMEOUT = ITER + 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cordic_ctrl_if.slave bus,
    output logic        dp_rst,
    output logic        dp_cnt_en,
    output logic [15:0] dp_angle,
    output logic [1:0]  dp_sector,
    input  logic        dp_done,
    input  logic [15:0] dp_sin,
    input  logic [15:0] dp_cos
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_sector;
    logic [13:0]        r_resid;
    logic [15:0]        r_dp_angle;
    logic [1:0]         r_dp_sector;
    logic [CNT_W-1:0]   r_run_cnt;
    logic [15:0]        r_rsp_sin;
    logic [15:0]        r_rsp_cos;
    logic               r_rsp_err;
    logic [15:0]        w_conv_angle;
    logic               w_accept;
    logic               w_run;
    logic               w_timeout;

    bam_to_rad u_bam_to_rad (
        .i_sector (r_sector),
        .i_resid  (r_resid),
        .o_angle  (w_conv_angle)
    );

    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    assign w_run     = (r_state == ST_RUN);
    assign w_timeout = w_run && (r_run_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: defaulting to the current state on every path keeps this purely combinational (no latch).
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.req_valid)          w_next = ST_CONV;
            ST_CONV:                             w_next = ST_LOAD;
            ST_LOAD:                             w_next = ST_RUN;
            ST_RUN:  if (dp_done || w_timeout)   w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready)          w_next = ST_IDLE;
            default:                             w_next = ST_IDLE;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sector    <= '0;
            r_resid     <= '0;
            r_dp_angle  <= '0;
            r_dp_sector <= '0;
            r_run_cnt   <= '0;
            r_rsp_sin   <= '0;
            r_rsp_cos   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sector <= bus.req_angle[15:14];
                r_resid  <= bus.req_angle[13:0];
            end

            if (r_state == ST_CONV) begin
                r_dp_sector <= r_sector;
                r_dp_angle  <= w_conv_angle;
            end

            if (r_state == ST_LOAD) begin
                r_run_cnt <= '0;
            end else if (w_run) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end

            // A done on the timeout cycle still counts as a normal completion.
            if (w_run && dp_done) begin
                r_rsp_sin <= dp_sin;
                r_rsp_cos <= dp_cos;
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_sin <= '0;
                r_rsp_cos <= '0;
                r_rsp_err <= 1'b1;
            end
        end
    end

    // The datapath is parked whenever it is not iterating, including during reset.
    assign dp_rst        = (r_state != ST_RUN) || !rst_n;
    assign dp_cnt_en     = w_run;
    assign dp_angle      = r_dp_angle;
    assign dp_sector     = r_dp_sector;

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_sin   = r_rsp_sin;
    assign bus.rsp_cos   = r_rsp_cos;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Self-checking bench for cordic_ctrl: a behavioural datapath stub plus a
// floating-point reference model of sin/cos over the full binary angle.
module tb_cordic_ctrl;

    localparam int  ITER    = 12;
    localparam int  TIMEOUT = 16;
    localparam real PI      = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dp_rst;
    logic        dp_cnt_en;
    logic [15:0] dp_angle;
    logic [1:0]  dp_sector;
    logic        dp_done;
    logic [15:0] dp_sin;
    logic [15:0] dp_cos;

    int  n_cmp = 0;
    int  n_bad = 0;

    int  stub_done_at;
    logic force_done;
    int  stub_cnt;
    real stub_base;
    real stub_theta;
    int  stub_sin;
    int  stub_cos;

    cordic_ctrl_if bus ();

    cordic_ctrl #(
        .ITER    (ITER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dp_rst    (dp_rst),
        .dp_cnt_en (dp_cnt_en),
        .dp_angle  (dp_angle),
        .dp_sector (dp_sector),
        .dp_done   (dp_done),
        .dp_sin    (dp_sin),
        .dp_cos    (dp_cos)
    );

    always #5 clk = ~clk;

    function automatic int q14(input real x);
        return int'($floor(x * 16384.0 + 0.5));
    endfunction

    // Datapath stub: counts RUN cycles from its load and shows the true result
    // only on its done cycle; other cycles carry junk so mistimed captures show up.
    always @(posedge clk) begin
        if (dp_rst) stub_cnt <= 0;
        else if (dp_cnt_en) stub_cnt <= stub_cnt + 1;
    end

    always_comb begin
        case (dp_sector)
            2'd0:    stub_base = 0.0;
            2'd1:    stub_base = PI / 2.0;
            2'd2:    stub_base = 3.0 * PI / 2.0;
            default: stub_base = 2.0 * PI;
        endcase
        stub_theta = $itor($signed(dp_angle)) / 16384.0 + stub_base;
        stub_sin   = q14($sin(stub_theta));
        stub_cos   = q14($cos(stub_theta));
    end

    assign dp_done = force_done || (dp_cnt_en && (stub_cnt == stub_done_at));
    assign dp_sin  = dp_done ? 16'(stub_sin) : 16'h5A5A + 16'(stub_cnt);
    assign dp_cos  = dp_done ? 16'(stub_cos) : 16'hA5A5 ^ 16'(stub_cnt);

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_cmp++;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) tol %0d", tag, obs, obs, exp, exp, tol);
        end
    endtask

    // Reference: quadrant/residual rules for the datapath operands, ideal trig for the answer.
    task automatic model(input logic [15:0] a, output int sect, output int ang,
                         output int s, output int c);
        int  r;
        int  rad;
        real theta;
        r     = int'(a & 16'h3FFF);
        rad   = (r * 25736 + 8192) / 16384;
        sect  = int'(a >> 14);
        ang   = (sect >= 2) ? rad - 25736 : rad;
        theta = $itor(a) * 2.0 * PI / 65536.0;
        s     = q14($sin(theta));
        c     = q14($cos(theta));
    endtask

    task automatic run_req(input logic [15:0] angle, input int done_at, input int hold);
        int n;
        int e_sect, e_ang, e_sin, e_cos, e_lat, tol;
        bit e_err;
        model(angle, e_sect, e_ang, e_sin, e_cos);
        e_err = !(done_at >= 0 && done_at < TIMEOUT);
        e_lat = e_err ? 3 + TIMEOUT : 4 + done_at;
        tol   = e_err ? 0 : 8;
        if (e_err) begin
            e_sin = 0;
            e_cos = 0;
        end
        stub_done_at = done_at;

        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_angle = angle;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_angle = 16'($urandom);
        n = 1;
        while (!bus.rsp_valid && n < 64) begin
            if (n == 2) begin
                check("load_sector", dp_sector, e_sect);
                check("load_angle", $signed(dp_angle), e_ang);
                check("load_dp_rst", dp_rst, 1);
                check("load_cnt_en", dp_cnt_en, 0);
            end
            if (n == 3) begin
                check("run_dp_rst", dp_rst, 0);
                check("run_cnt_en", dp_cnt_en, 1);
                check("run_req_ready", bus.req_ready, 0);
            end
            @(negedge clk);
            n++;
        end
        check("latency", n, e_lat);
        check("rsp_err", bus.rsp_err, e_err);
        check("rsp_sin", $signed(bus.rsp_sin), e_sin, tol);
        check("rsp_cos", $signed(bus.rsp_cos), e_cos, tol);
        check("resp_dp_rst", dp_rst, 1);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_ready", bus.req_ready, 0);
            check("hold_dp_rst", dp_rst, 1);
            check("hold_sin", $signed(bus.rsp_sin), e_sin, tol);
            check("hold_cos", $signed(bus.rsp_cos), e_cos, tol);
            check("hold_err", bus.rsp_err, e_err);
        end

        // A request offered alongside the response hand-off must not be taken on that edge.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("release_valid", bus.rsp_valid, 0);
        check("release_idle", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_angle = '0;
        bus.rsp_ready = 1'b0;
        force_done    = 1'b0;
        stub_done_at  = ITER - 1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_sin", bus.rsp_sin, 0);
        check("rst_rsp_cos", bus.rsp_cos, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_cnt_en", dp_cnt_en, 0);
        check("rst_dp_rst", dp_rst, 1);
        check("rst_dp_angle", dp_angle, 0);
        check("rst_dp_sector", dp_sector, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_dp_rst", dp_rst, 1);

        force_done = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_done_valid", bus.rsp_valid, 0);
        check("stray_done_idle", bus.req_ready, 1);
        force_done = 1'b0;

        run_req(16'h0000, ITER - 1, 0);
        run_req(16'h4000, ITER - 1, 0);
        run_req(16'hA000, ITER - 1, 0);
        run_req(16'hE000, ITER - 1, 5);
        run_req(16'h1234, -1, 2);
        run_req(16'h6789, TIMEOUT - 1, 0);
        run_req(16'hFFFF, 0, 1);

        // Reset on the fifth RUN cycle abandons the in-flight request.
        stub_done_at  = ITER - 1;
        bus.req_valid = 1'b1;
        bus.req_angle = 16'h3000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (n < 7) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.rsp_valid, 0);
        check("midrst_dp_rst", dp_rst, 1);
        check("midrst_cnt_en", dp_cnt_en, 0);
        check("midrst_ready", bus.req_ready, 1);
        check("midrst_sin", bus.rsp_sin, 0);
        check("midrst_angle", dp_angle, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req(16'h2000, ITER - 1, 0);

        for (int k = 0; k < 24; k++) begin
            int sel;
            int d_at;
            sel = $urandom_range(0, 7);
            if (sel == 0) d_at = -1;
            else if (sel == 1) d_at = $urandom_range(0, TIMEOUT - 1);
            else d_at = ITER - 1;
            run_req(16'($urandom), d_at, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
